// File: rtl/dmem_axi_master.sv
// dmem_axi_master: bridges a single-cycle data-memory port onto AXI4.
// Each transfer is one beat, and only one transaction is in flight at a time.
// Ports:
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   dmem_addr/ren/wen      core request (wen wins when both are set)
//   dmem_wstrb/wdata       core write payload
//   dmem_rdata             registered read data; holds until the next read completes
//   dmem_stall             combinational pipeline hold
//   AR/R/AW/W/B            AXI4 master channels (single beat, ID = MASTER_ID)
//   dmem_err               sticky bus-error flag
// Build option: define DMEM_AXI_ERR_CHECK_EN to make dmem_err capture non-OKAY
// RRESP/BRESP. Without it, dmem_err is tied to 0.
module dmem_axi_master (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_ren,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_stall,
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    output logic        dmem_err
);

    localparam int unsigned XLEN          = 32;
    localparam int unsigned AXI_ADDR_BITS = 32;
    localparam int unsigned AXI_DATA_BITS = 32;
    localparam int unsigned AXI_ID_BITS   = 4;
    localparam int unsigned STRB_BITS     = AXI_DATA_BITS / 8;
    localparam logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd1;

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [AXI_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]            wdata_q, wdata_d;
    logic [STRB_BITS-1:0]       wstrb_q, wstrb_d;
    logic                       aw_done_q, aw_done_d;
    logic                       w_done_q, w_done_d;
    logic [XLEN-1:0]            rdata_d;
    logic                       arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;

    // Fixed single-beat burst attributes; payload comes from the latched request
    assign ARID    = MASTER_ID;
    assign ARLEN   = 4'd0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign ARADDR  = addr_q;
    assign AWID    = MASTER_ID;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign AWADDR  = addr_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;

    // Hold the core from the request cycle until DONE
    assign dmem_stall = (state_q == IDLE) ? (dmem_ren | dmem_wen) : (state_q != DONE);

`ifdef DMEM_AXI_ERR_CHECK_EN
    logic err_q, err_d;
    logic unused_ids;
    assign unused_ids = ^{RID, BID, RLAST};
    assign dmem_err   = err_q;
`else
    logic unused_ids;
    assign unused_ids = ^{RID, BID, RLAST, RRESP, BRESP};
    assign dmem_err   = 1'b0;
`endif

    // Next-state, payload capture and next values of the registered handshake outputs
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = dmem_rdata;
`ifdef DMEM_AXI_ERR_CHECK_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (dmem_wen) begin
                    addr_d    = dmem_addr;
                    wdata_d   = dmem_wdata;
                    wstrb_d   = dmem_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_REQ;
                end else if (dmem_ren) begin
                    addr_d  = dmem_addr;
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (ARVALID && ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (RVALID && RREADY) begin
                    rdata_d = RDATA;
`ifdef DMEM_AXI_ERR_CHECK_EN
                    if (RRESP != 2'b00) err_d = 1'b1;
`endif
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                // AW and W complete independently, possibly in the same cycle
                if (AWVALID && AWREADY) aw_done_d = 1'b1;
                if (WVALID && WREADY)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (BVALID && BREADY) begin
`ifdef DMEM_AXI_ERR_CHECK_EN
                    if (BRESP != 2'b00) err_d = 1'b1;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        arvalid_d = (state_d == RD_ADDR);
        rready_d  = (state_d == RD_DATA);
        awvalid_d = (state_d == WR_REQ) && !aw_done_d;
        wvalid_d  = (state_d == WR_REQ) && !w_done_d;
        bready_d  = (state_d == WR_RESP);
    end

    // State, payload and output registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            dmem_rdata <= '0;
            ARVALID    <= 1'b0;
            RREADY     <= 1'b0;
            AWVALID    <= 1'b0;
            WVALID     <= 1'b0;
            BREADY     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            dmem_rdata <= rdata_d;
            ARVALID    <= arvalid_d;
            RREADY     <= rready_d;
            AWVALID    <= awvalid_d;
            WVALID     <= wvalid_d;
            BREADY     <= bready_d;
        end
    end

`ifdef DMEM_AXI_ERR_CHECK_EN
    // Sticky error flag, cleared only by reset
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) err_q <= 1'b0;
        else          err_q <= err_d;
    end
`endif

endmodule
